pad_share_arbiter: RTL

- Arbitrates a shared group of bidirectional FPGA pads (IOBUF-based pad models) between NREQ on-chip requesters.
- Sequences ownership with a guaranteed tristate turnaround gap between owners, so two drivers never contend on the pad.
- Drives the pad-model data and tristate controls, and returns registered pad input data.
- Sits between peripheral pin logic and the pad ring in the FPGA tech library.

---
 rtl/pad_share_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter: round-robin owner sequencing for a shared IOBUF pad group with a tristate gap between owners.
// Optional owner hold timeout under contention: define PAD_SHARE_ARB_TIMEOUT_EN.
module pad_share_arbiter #(
    parameter int NREQ        = 2,
    parameter int PADW        = 8,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_MAX    = 64
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      drv_en_i,
    input  logic [NREQ*PADW-1:0] dout_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [PADW-1:0]      pad_o,
    output logic [PADW-1:0]      pad_t_o,
    input  logic [PADW-1:0]      pad_i,
    output logic [PADW-1:0]      din_o,
    output logic                 busy_o
);
    localparam int         IW      = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_OWN   = 2'd2;
    localparam logic [3:0] TURN_LD = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);

    generate
        if (NREQ < 2 || NREQ > 4 || TURN_CYCLES < 0 || TURN_CYCLES > 15 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_param
            $error("pad_share_arbiter: parameter out of range");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [IW-1:0]   r_win;
    logic [IW-1:0]   r_ptr;
    logic [3:0]      r_cnt;
    logic [NREQ-1:0] r_grant;
    logic [PADW-1:0] r_pad_o;
    logic [PADW-1:0] r_pad_t;
    logic [PADW-1:0] r_din;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_next_ptr;
    logic [NREQ-1:0] w_win_oh;
    logic [NREQ-1:0] w_pick_oh;
    logic            w_own_req;
    logic            w_release;

    // Scan backwards so the lowest offset from the pointer is assigned last and wins.
    always_comb begin
        w_win = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[(int'(r_ptr) + i) % NREQ]) w_win = IW'((int'(r_ptr) + i) % NREQ);
        end
    end

    assign w_own_req  = req_i[r_win];
    assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_win;
    assign w_pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_next_ptr = (int'(r_win) == NREQ - 1) ? '0 : r_win + 1'b1;

`ifdef PAD_SHARE_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_MAX);
    logic [15:0] r_hold;
    logic        w_other;
    assign w_other   = |(req_i & ~w_win_oh);
    assign w_release = ~w_own_req | ((r_hold >= HOLD_LIM) & w_other);
    // Held at 1 outside OWN so the first owned cycle already counts as one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_hold <= 16'd1;
        else if (r_state != S_OWN) r_hold <= 16'd1;
        else if (r_hold < HOLD_LIM) r_hold <= r_hold + 16'd1;
    end
`else
    assign w_release = ~w_own_req;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_pad_o <= '0;
            r_pad_t <= '1;
            r_din   <= '0;
        end else begin
            r_din <= pad_i;
            case (r_state)
                S_IDLE: if (|req_i) begin
                    r_win <= w_win;
                    if (TURN_CYCLES == 0) begin
                        r_state <= S_OWN;
                        r_grant <= w_pick_oh;
                    end else begin
                        r_state <= S_TURN;
                        r_cnt   <= TURN_LD;
                    end
                end
                S_TURN: if (!w_own_req) r_state <= S_IDLE;
                else if (r_cnt == 4'd0) begin
                    r_state <= S_OWN;
                    r_grant <= w_win_oh;
                end else r_cnt <= r_cnt - 4'd1;
                S_OWN: if (w_release) begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_pad_t <= '1;
                    r_ptr   <= w_next_ptr;
                end else begin
                    r_pad_o <= dout_i[r_win*PADW +: PADW];
                    r_pad_t <= {PADW{~drv_en_i[r_win]}};
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign pad_o   = r_pad_o;
    assign pad_t_o = r_pad_t;
    assign din_o   = r_din;
    assign busy_o  = (r_state != S_IDLE);
endmodule
